// File: rtl/memory_arbiter.sv
// memory_arbiter: responder end of the request-unit interface. Serializes
// instruction fetches and data reads/writes onto a single-port RAM with
// variable latency, alternates grants when both sides are pending, and
// aborts any access that stalls longer than TIMEOUT cycles.
module memory_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] BAD_WORD = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              err
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

  // last_grant encoding
  localparam logic G_INSTR = 1'b0;
  localparam logic G_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_INSTR = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              err_q, err_d;

  logic d_pend, i_pend, grant_d, grant_i, done;

  // Next-state logic: arbitration in IDLE, ack/watchdog completion in the
  // access states, and a single HOLD cycle so a still-asserted request is
  // not served twice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    iload_d = iload_q;
    dload_d = dload_q;
    err_d   = err_q;
    d_pend  = dmemREN | dmemWEN;
    i_pend  = iREN;
    grant_d = d_pend && (!i_pend || last_q == G_INSTR);
    grant_i = i_pend && !grant_d;
    done    = ram_ack || (cnt_q == CNT_MAX);
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d = S_DATA;
          addr_d  = daddr;
          wdata_d = dstore;
          wr_d    = dmemWEN;   // read+write together resolves to a write
          cnt_d   = '0;
        end else if (grant_i) begin
          state_d = S_INSTR;
          addr_d  = iaddr;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (done) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          dhit_d  = 1'b1;
          last_d  = G_DATA;
          if (ram_ack) begin
            dload_d = wr_q ? '0 : ram_rdata;
          end else begin
            dload_d = BAD_WORD;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INSTR: begin
        if (done) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          ihit_d  = 1'b1;
          last_d  = G_INSTR;
          if (ram_ack) begin
            iload_d = ram_rdata;
          end else begin
            iload_d = BAD_WORD;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including any
  // in-flight access, which then completes without a hit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= G_INSTR;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
    end
  end

  assign ram_ren   = (state_q == S_INSTR) || (state_q == S_DATA && !wr_q);
  assign ram_wen   = (state_q == S_DATA) && wr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign err       = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter (TIMEOUT = 4). The bench plays the
// RAM: it raises ram_ack/ram_rdata for chosen access cycles.
module tb_memory_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN, dmemREN, dmemWEN;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit, dhit, ram_ren, ram_wen, err, ram_ack;
  logic [DATA_W-1:0] iload, dload, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  int n_chk  = 0;
  int n_fail = 0;
  logic done_run = 1'b0;

  memory_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (4),
    .BAD_WORD(32'hBAD1BAD1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .iload    (iload),
    .dhit     (dhit),
    .dload    (dload),
    .ram_ren  (ram_ren),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_ack  (ram_ack),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // mutual exclusion of hits and of RAM enables, every cycle
  always @(negedge CLK) begin
    if (!done_run) begin
      check_eq("hit_excl", {63'd0, ihit & dhit}, 64'd0);
      check_eq("en_excl",  {63'd0, ram_ren & ram_wen}, 64'd0);
    end
  end

  initial begin
    RST = 1'b1; iREN = 0; dmemREN = 0; dmemWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ram_ack = 0; ram_rdata = '0;
    step();
    step();
    check_eq("rst_ren",   ram_ren,   0);
    check_eq("rst_wen",   ram_wen,   0);
    check_eq("rst_addr",  ram_addr,  0);
    check_eq("rst_wdata", ram_wdata, 0);
    check_eq("rst_err",   err,       0);
    check_eq("rst_ihit",  ihit,      0);
    check_eq("rst_dhit",  dhit,      0);
    check_eq("rst_iload", iload,     0);
    check_eq("rst_dload", dload,     0);

    // ---- reset mid-fetch
    RST = 0; iREN = 1; iaddr = 32'h40;
    step();
    check_eq("mf_ren1",  ram_ren,  1);
    check_eq("mf_addr",  ram_addr, 32'h40);
    step();
    check_eq("mf_ren2",  ram_ren,  1);
    RST = 1;
    step();
    check_eq("mf_ren_drop", ram_ren,  0);
    check_eq("mf_ihit",     ihit,     0);
    check_eq("mf_addr0",    ram_addr, 0);
    check_eq("mf_iload",    iload,    0);
    iREN = 0; RST = 0;
    step();
    check_eq("mf_ihit2", ihit,    0);
    check_eq("mf_idle",  ram_ren, 0);

    // ---- single read, ack in first enabled cycle
    dmemREN = 1; daddr = 32'h100;
    step();
    check_eq("rd_ren",  ram_ren,  1);
    check_eq("rd_wen",  ram_wen,  0);
    check_eq("rd_addr", ram_addr, 32'h100);
    check_eq("rd_dhit_early", dhit, 0);
    ram_ack = 1; ram_rdata = 32'h12345678;
    step();
    ram_ack = 0; ram_rdata = '0;
    check_eq("rd_ren_off", ram_ren, 0);
    check_eq("rd_dhit",    dhit,    1);
    check_eq("rd_dload",   dload,   32'h12345678);
    check_eq("rd_ihit",    ihit,    0);
    dmemREN = 0;
    step();
    check_eq("rd_dhit_clr", dhit, 0);

    // ---- write priority and latched write data
    dmemREN = 1; dmemWEN = 1; daddr = 32'h8; dstore = 32'hCAFEF00D;
    step();
    check_eq("wr_wen",   ram_wen,   1);
    check_eq("wr_ren",   ram_ren,   0);
    check_eq("wr_addr",  ram_addr,  32'h8);
    check_eq("wr_wdata", ram_wdata, 32'hCAFEF00D);
    dstore = 32'h11111111; daddr = 32'h77;
    step();
    check_eq("wr_wdata_latched", ram_wdata, 32'hCAFEF00D);
    check_eq("wr_addr_latched",  ram_addr,  32'h8);
    ram_ack = 1; ram_rdata = 32'hFFFFFFFF;
    step();
    ram_ack = 0;
    check_eq("wr_dhit",  dhit,    1);
    check_eq("wr_dload", dload,   0);
    check_eq("wr_wen_off", ram_wen, 0);
    dmemREN = 0; dmemWEN = 0;
    step();

    // ---- withdrawn request, ack on the last cycle before the watchdog
    dmemREN = 1; daddr = 32'h20;
    step();
    dmemREN = 0;
    check_eq("wd_ren0", ram_ren, 1);
    step();
    step();
    step();
    check_eq("wd_ren3", ram_ren, 1);
    ram_ack = 1; ram_rdata = 32'h55AA55AA;
    step();
    ram_ack = 0;
    check_eq("wd_dhit",  dhit,  1);
    check_eq("wd_dload", dload, 32'h55AA55AA);
    check_eq("wd_err",   err,   0);
    step();
    check_eq("wd_dhit_clr", dhit,    0);
    step();
    check_eq("wd_no_second", ram_ren, 0);

    // ---- stray ack in IDLE is ignored
    ram_ack = 1; ram_rdata = 32'hDEAD;
    step();
    ram_ack = 0;
    check_eq("stray_dhit", dhit, 0);
    check_eq("stray_ihit", ihit, 0);
    step();
    check_eq("stray_dhit2", dhit, 0);

    // ---- fairness: both held, D first after reset
    RST = 1;
    step();
    RST = 0;
    iREN = 1; dmemREN = 1; iaddr = 32'h400; daddr = 32'h800;
    for (int g = 0; g < 4; g++) begin
      logic is_d;
      is_d = (g % 2 == 0);
      step();
      check_eq($sformatf("fr_ren_%0d", g), ram_ren, 1);
      check_eq($sformatf("fr_addr_%0d", g), ram_addr,
               is_d ? 32'h800 : 32'h400);
      step();
      ram_ack = 1; ram_rdata = 32'hA000 + g;
      step();
      ram_ack = 0;
      check_eq($sformatf("fr_dhit_%0d", g), dhit, is_d);
      check_eq($sformatf("fr_ihit_%0d", g), ihit, !is_d);
      if (is_d) check_eq($sformatf("fr_dload_%0d", g), dload, 32'hA000 + g);
      else      check_eq($sformatf("fr_iload_%0d", g), iload, 32'hA000 + g);
      step();
      check_eq($sformatf("fr_hitw_%0d", g), {ihit, dhit}, 0);
      check_eq($sformatf("fr_gap_%0d", g), ram_ren, 0);
    end
    iREN = 0; dmemREN = 0;
    step();

    // ---- watchdog abort on a fetch
    iREN = 1; iaddr = 32'h44;
    step();
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("to_ren_%0d", c), ram_ren, 1);
      check_eq($sformatf("to_ihit_%0d", c), ihit, 0);
      step();
    end
    check_eq("to_ren_off", ram_ren, 0);
    check_eq("to_ihit",    ihit,    1);
    check_eq("to_iload",   iload,   32'hBAD1BAD1);
    check_eq("to_err",     err,     1);
    iREN = 0;
    step();
    check_eq("to_ihit_clr", ihit, 0);
    step();
    step();
    check_eq("to_err_sticky", err, 1);
    RST = 1;
    step();
    check_eq("to_err_rst", err, 0);
    RST = 0;
    step();

    done_run = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder end of the request-unit interface. Accepts instruction fetches (iREN) and data reads/writes (dmemREN/dmemWEN) from the datapath side.
- Serializes them onto a single-port RAM with variable latency.
- Returns one-cycle ihit/dhit pulses with registered load data.
- Sits between the datapath's request unit and the RAM model/bus. Provides fair arbitration, write priority and a stall watchdog.

Parameters:
- ADDR_W, 32, address width for iaddr, daddr and ram_addr
- DATA_W, 32, data word width
- TIMEOUT, 64, cycles in an access state without ram_ack before the access is aborted (min 2)
- BAD_WORD, 32'hBAD1BAD1, load value returned on an aborted access

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  instruction fetch request
- iaddr  in  ADDR_W  fetch address
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- ihit  out  1  fetch complete, one-cycle pulse
- iload  out  DATA_W  fetched word, valid while ihit=1
- dhit  out  1  data access complete, one-cycle pulse
- dload  out  DATA_W  read word, valid while dhit=1 (read) or 0 (write)
- ram_ren  out  1  RAM read enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM access complete, one-cycle pulse
- err  out  1  sticky watchdog-abort flag

Behaviour:
- Clocking and reset: all state changes on the rising edge of CLK. RST=1 at an edge forces every output to 0 (ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_wdata, err), state to IDLE, watchdog count to 0 and last_grant to INSTR. This applies mid-transaction too: the RAM enables drop in the cycle after the reset edge and the in-flight access is discarded with no hit.
- IDLE: samples requests. Data is pending if dmemREN|dmemWEN; instruction is pending if iREN.
  - Only data pending → DATA.
  - Only instruction pending → INSTR.
  - Both pending → INSTR if last_grant=DATA, else DATA (alternation, no starvation).
- Grant latching: on entry to DATA/INSTR, latch address, write data and op. If dmemREN and dmemWEN are both 1, the access is a write.
- DATA/INSTR:
  - Drive ram_ren or ram_wen (exactly one) with ram_addr and ram_wdata from the latched registers; the inputs are not re-read.
  - The watchdog counter increments each cycle.
  - On ram_ack: clear the enables, capture ram_rdata into iload or dload (dload=0 for a write), pulse the matching hit, update last_grant, go to HOLD.
  - When the watchdog reaches TIMEOUT-1 with no ack: same path, but load = BAD_WORD and err←1.
- HOLD: exactly one cycle. The hit is high here and the requester advances on the following edge. Next state is IDLE and the hit clears. No request is sampled in HOLD, which prevents re-serving a request the requester has not yet dropped.
- Latency: minimum 3 cycles from request to hit.
  - Request seen at edge E0.
  - Enables high in cycle E0+1.
  - Ack sampled at E1.
  - Hit high in cycle E1+1.
- Withdrawn request: if a request drops while in DATA/INSTR, the RAM access still completes and the hit still pulses. The requester ignores it.
- ram_ack outside DATA/INSTR is ignored.
- ihit and dhit are never high in the same cycle. ram_ren and ram_wen are never both high.
- err stays set until RST.

Test Plan:
- Reset mid-fetch: iREN=1, iaddr=0x40, RST at cycle 2 of INSTR → ram_ren=0 next cycle, no ihit, all outputs 0.
- Single read: dmemREN=1, daddr=0x100, ram_ack at first enabled cycle with ram_rdata=0x12345678 → ram_ren=1 for 1 cycle, dhit=1 exactly 3 cycles after request, dload=0x12345678, ihit=0.
- Write priority: dmemREN=dmemWEN=1, daddr=0x8, dstore=0xCAFEF00D → ram_wen=1, ram_ren=0, ram_wdata=0xCAFEF00D, dhit pulse with dload=0.
- Fairness: iREN and dmemREN held high continuously, ack after 2 cycles each → grants alternate D,I,D,I starting with D after reset, each hit one cycle wide, a HOLD cycle between grants.
- Watchdog: TIMEOUT=4, iREN=1, ram_ack never → ram_ren high 4 cycles, then ihit=1, iload=0xBAD1BAD1, err=1 and stays 1 until RST.
- Withdrawn request: dmemREN dropped one cycle into DATA, ack 3 cycles later → dhit still pulses once, then return to IDLE with no second access.
